// File: rtl/fpu_ex_ctrl.sv
// fpu_ex_ctrl: EX-stage sequencer for the combined ALU/FPU datapath.
// Single-cycle ops pass through. Multi-cycle FPU ops are issued with a
// registered start pulse. EX stalls until the FPU reports done or a
// watchdog expires. The result is then presented for one write-back cycle.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_valid, i_multi, i_alu_op,
//   i_rd, i_flush                  EX instruction and kill
//   i_fpu_done, i_fpu_data         FPU completion handshake
//   o_fpu_start, o_alu_op          FPU issue controls
//   o_stall                        pipeline freeze (combinational)
//   o_wb_valid, o_result, o_rd     one-cycle write-back
//   o_timeout, o_stall_cnt         sticky error flag, stall perf counter
module fpu_ex_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7,
  parameter int PERF_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_multi,
  input  logic [4:0]        i_alu_op,
  input  logic [4:0]        i_rd,
  input  logic              i_flush,
  input  logic              i_fpu_done,
  input  logic [DATA_W-1:0] i_fpu_data,
  output logic              o_fpu_start,
  output logic [4:0]        o_alu_op,
  output logic              o_stall,
  output logic              o_wb_valid,
  output logic [DATA_W-1:0] o_result,
  output logic [4:0]        o_rd,
  output logic              o_timeout,
  output logic [PERF_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  localparam logic [DATA_W-1:0] CANON_NAN = DATA_W'(32'h7FC0_0000);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] busy_cnt;
  logic             wb_kill;   // op was flushed while completing: no write-back
  logic             accept;
  logic             tmo_hit;

  assign accept  = (state == IDLE) && i_valid && i_multi && !i_flush;
  // Counter is 0 in the first BUSY cycle, so this is the TIMEOUT-th cycle.
  assign tmo_hit = (busy_cnt == TMO_LAST);

  // Next state and combinational outputs
  always_comb begin
    state_nxt  = state;
    o_stall    = 1'b0;
    o_wb_valid = 1'b0;
    case (state)
      IDLE: begin
        o_stall = accept;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        o_stall = 1'b1;
        // done > timeout > flush
        if (i_fpu_done || tmo_hit) state_nxt = DONE;
        else if (i_flush)          state_nxt = DRAIN;
      end
      DONE: begin
        o_wb_valid = !wb_kill;
        state_nxt  = IDLE;
      end
      DRAIN: begin
        // Only a waiting multi op has to be held back while the FPU drains.
        o_stall = i_valid && i_multi;
        if (i_fpu_done || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      busy_cnt    <= '0;
      wb_kill     <= 1'b0;
      o_fpu_start <= 1'b0;
      o_alu_op    <= '0;
      o_rd        <= '0;
      o_result    <= '0;
      o_timeout   <= 1'b0;
      o_stall_cnt <= '0;
    end else begin
      state       <= state_nxt;
      o_fpu_start <= accept;

      if (accept) begin
        o_alu_op <= i_alu_op;
        o_rd     <= i_rd;
        busy_cnt <= '0;
        wb_kill  <= 1'b0;
      end else if (state == BUSY || state == DRAIN) begin
        busy_cnt <= busy_cnt + 1'b1;
      end

      if (state == BUSY) begin
        if (i_fpu_done) begin
          o_result <= i_fpu_data;
          wb_kill  <= i_flush;
        end else if (tmo_hit) begin
          o_result  <= CANON_NAN;
          o_timeout <= 1'b1;
          wb_kill   <= i_flush;
        end
      end

      // Drain discards FPU data but still reports a hung unit.
      if (state == DRAIN && !i_fpu_done && tmo_hit)
        o_timeout <= 1'b1;

      if (o_stall && !(&o_stall_cnt))
        o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

endmodule
